// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, requester ID
// width and the response-buffer state encoding.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  localparam int ID_W = 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU. Unknown opcodes pass A through; zero is only
// reported for SUB.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         zero
);

  localparam int SH_W = $clog2(N);

  logic shift_oob;
  assign shift_oob = |b[N-1:SH_W];

  // NOTE: result gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    result = a;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_SLL:  result = shift_oob ? '0 : (a << b[SH_W-1:0]);
      OP_SRL:  result = shift_oob ? '0 : (a >> b[SH_W-1:0]);
      OP_SLT:  result = {{(N-1){1'b0}}, (a < b)};
      default: result = a;
    endcase
  end

  assign zero = (op == OP_SUB) && (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters, with a
// single-entry registered response buffer that can drain and refill each cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [N-1:0]    req0_a,
  input  logic [N-1:0]    req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [N-1:0]    req1_a,
  input  logic [N-1:0]    req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [N-1:0]    rsp_result,
  output logic            rsp_zero,
  output logic [15:0]     busy_cycles
);

  logic [0:0]   state;
  logic         last_grant;
  logic         can_issue;
  logic         grant0;
  logic         grant1;
  logic [3:0]   alu_op;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_result;
  logic         alu_zero;
  logic         sub_equal;

  assign rsp_valid = (state == ST_FULL);
  assign can_issue = (state == ST_EMPTY) || rsp_ready;

  // On conflict the requester that did not win last time goes next.
  assign grant0 = can_issue & req0_valid & (~req1_valid | last_grant);
  assign grant1 = can_issue & req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = grant0 & ~rst;
  assign req1_ready = grant1 & ~rst;

  assign alu_op = grant1 ? req1_op : (grant0 ? req0_op : OP_ADD);
  assign alu_a  = grant1 ? req1_a  : req0_a;
  assign alu_b  = grant1 ? req1_b  : req0_b;

  alu_arbiter_alu #(.N(N)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign sub_equal = (alu_op == OP_SUB) && (alu_a == alu_b);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      last_grant  <= 1'b1;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      busy_cycles <= '0;
    end else begin
      if (grant0 || grant1) begin
        state      <= ST_FULL;
        last_grant <= grant1;
        rsp_id     <= ID_W'(grant1);
        rsp_result <= sub_equal ? '0 : alu_result;
        rsp_zero   <= sub_equal ? 1'b1 : alu_zero;
      end else if (state == ST_FULL && rsp_ready) begin
        state <= ST_EMPTY;
      end

      if (state == ST_FULL && !rsp_ready && busy_cycles != 16'hFFFF)
        busy_cycles <= busy_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: handshake, round-robin order,
// stall behaviour, reset while full and ALU corner cases.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [3:0]   req0_op;
  logic [N-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [3:0]   req1_op;
  logic [N-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [N-1:0] rsp_result;
  logic         rsp_zero;
  logic [15:0]  busy_cycles;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .busy_cycles (busy_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] id, input logic [31:0] res, input logic [31:0] z);
    check({tag, "_valid"},  32'(rsp_valid), 32'd1);
    check({tag, "_id"},     32'(rsp_id), id);
    check({tag, "_result"}, rsp_result, res);
    check({tag, "_zero"},   32'(rsp_zero), z);
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_req0(1'b1, OP_ADD, 32'd1, 32'd1);
    set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
    step();
    step();
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    check("rst_busy", 32'(busy_cycles), 32'd0);

    // ADD 5+7 from requester 0
    rst = 1'b0;
    set_req0(1'b1, OP_ADD, 32'd5, 32'd7);
    #1;
    check("add_req0_ready", 32'(req0_ready), 32'd1);
    step();
    set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
    check_rsp("add", 32'd0, 32'd12, 32'd0);

    // SUB with equal operands, then unequal, from requester 1
    set_req1(1'b1, OP_SUB, 32'd9, 32'd9);
    #1;
    check("sub_eq_req1_ready", 32'(req1_ready), 32'd1);
    step();
    check_rsp("sub_eq", 32'd1, 32'd0, 32'd1);
    set_req1(1'b1, OP_SUB, 32'd9, 32'd4);
    step();
    check_rsp("sub_ne", 32'd1, 32'd5, 32'd0);

    // Both valid every cycle: grants alternate starting with requester 0
    set_req0(1'b1, OP_ADD, 32'd100, 32'd1);
    set_req1(1'b1, OP_XOR, 32'h0000_00F0, 32'h0000_000F);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("alt%0d_req0_ready", i), 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("alt%0d_req1_ready", i), 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      if (i % 2 == 0) check_rsp($sformatf("alt%0d", i), 32'd0, 32'd101, 32'd0);
      else            check_rsp($sformatf("alt%0d", i), 32'd1, 32'h0000_00FF, 32'd0);
    end

    // Stall: response held for 3 cycles while requester 0 waits
    set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
    set_req0(1'b1, OP_OR, 32'h30, 32'h03);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d_req0_ready", i), 32'(req0_ready), 32'd0);
      step();
      check_rsp($sformatf("stall%0d", i), 32'd1, 32'h0000_00FF, 32'd0);
    end
    check("stall_busy", 32'(busy_cycles), 32'd3);
    rsp_ready = 1'b1;
    #1;
    check("drain_req0_ready", 32'(req0_ready), 32'd1);
    step();
    check_rsp("drain_or", 32'd0, 32'h33, 32'd0);
    check("drain_busy", 32'(busy_cycles), 32'd3);

    // Reset while full with requester 1 pending
    set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
    set_req1(1'b1, OP_AND, 32'hFF, 32'h0F);
    rsp_ready = 1'b0;
    step();
    check("pre_rst_busy", 32'(busy_cycles), 32'd4);
    rst = 1'b1;
    #1;
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    step();
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_busy", 32'(busy_cycles), 32'd0);
    check("post_rst_id", 32'(rsp_id), 32'd0);

    // After reset requester 0 wins the first conflict
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req0(1'b1, OP_SLL, 32'd1, 32'd31);
    set_req1(1'b1, OP_SLT, 32'd3, 32'd2);
    #1;
    check("rr_req0_ready", 32'(req0_ready), 32'd1);
    check("rr_req1_ready", 32'(req1_ready), 32'd0);
    step();
    check_rsp("sll", 32'd0, 32'h8000_0000, 32'd0);
    set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
    #1;
    check("slt_req1_ready", 32'(req1_ready), 32'd1);
    step();
    check_rsp("slt", 32'd1, 32'd0, 32'd0);

    // Passthrough opcode and oversized shift
    set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
    set_req0(1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
    step();
    check_rsp("pass", 32'd0, 32'hDEAD_BEEF, 32'd0);
    set_req0(1'b1, OP_SRL, 32'hFFFF_FFFF, 32'd32);
    step();
    check_rsp("srl_oob", 32'd0, 32'd0, 32'd0);

    // Drain with nothing pending: valid drops, data holds
    set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
    step();
    check("idle_valid", 32'(rsp_valid), 32'd0);
    check("idle_id_hold", 32'(rsp_id), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
